// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared constants and types for the quad-core instruction ROM fetch arbiter.
package rom_fetch_arbiter_pkg;

    localparam int unsigned NCORES = 4;
    localparam int unsigned LANE_W = 64;
    localparam int unsigned DATA_W = NCORES * LANE_W;

    localparam int unsigned ROM_DEPTH_DEFAULT  = 4096;
    localparam int unsigned SETUP_CYC_DEFAULT  = 3;
    localparam int unsigned ACCESS_CYC_DEFAULT = 3;
    localparam int unsigned HOLD_CYC_DEFAULT   = 3;

    // Phase counter width; comfortably covers any sane phase length.
    localparam int unsigned CNT_W = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StHold
    } fetch_state_e;

    // Core k owns the lane whose MSB sits at DATA_W-1-k*LANE_W (core 0 is the top lane).
    function automatic int unsigned lane_msb(input int unsigned core);
        return DATA_W - 1 - LANE_W * core;
    endfunction

endpackage

// File: rtl/rom_fetch_arbiter_rr_arbiter4.sv
// Four-way round-robin arbiter: searches from the pointer, skips masked cores,
// and moves the pointer past the winner whenever a grant is taken.
module rr_arbiter4
    import rom_fetch_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NCORES-1:0] req,
    input  logic [NCORES-1:0] mask,
    input  logic              advance,
    output logic [NCORES-1:0] gnt,
    output logic              gnt_valid,
    output logic [1:0]        gnt_idx
);

    logic [1:0]        ptr_q;
    logic [1:0]        cand;
    logic [NCORES-1:0] elig;

    // First eligible core at or after the pointer, wrapping modulo 4.
    always_comb begin
        elig      = req & ~mask;
        gnt_valid = 1'b0;
        gnt_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 0; i < NCORES; i++) begin
            cand = ptr_q + 2'(i);
            if (!gnt_valid && elig[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
        gnt          = '0;
        gnt[gnt_idx] = gnt_valid;
    end

    // Pointer moves to the core after the winner on every taken grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 2'd0;
        end else if (advance && gnt_valid) begin
            ptr_q <= gnt_idx + 2'd1;
        end
    end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Serialises four cores' fetches onto the shared quad-port ROM bus, sequencing
// notOE/notCE so the bus has a single driver and the ROM timing is honoured.
module rom_fetch_arbiter
    import rom_fetch_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 54,
    parameter int unsigned ROM_DEPTH  = ROM_DEPTH_DEFAULT,
    parameter int unsigned SETUP_CYC  = SETUP_CYC_DEFAULT,
    parameter int unsigned ACCESS_CYC = ACCESS_CYC_DEFAULT,
    parameter int unsigned HOLD_CYC   = HOLD_CYC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCORES-1:0]        fetch_req,
    input  logic [NCORES*ADDR_W-1:0] fetch_addr,
    output logic [NCORES-1:0]        fetch_ack,
    output logic [NCORES-1:0]        fetch_err,
    output logic [DATA_W-1:0]        fetch_data,
    output logic [ADDR_W-1:0]        rom_addr1,
    output logic [ADDR_W-1:0]        rom_addr2,
    output logic [ADDR_W-1:0]        rom_addr3,
    output logic [ADDR_W-1:0]        rom_addr4,
    output logic                     rom_notOE1,
    output logic                     rom_notOE2,
    output logic                     rom_notOE3,
    output logic                     rom_notOE4,
    output logic                     rom_notCE,
    input  logic [DATA_W-1:0]        rom_data
);

    fetch_state_e      state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    logic [1:0]        core_q, core_d;
    logic [NCORES-1:0] ack_q, ack_d;
    logic [NCORES-1:0] err_q, err_d;
    logic [NCORES-1:0] oe_n_q, oe_n_d;
    logic              ce_n_q, ce_n_d;
    logic [ADDR_W-1:0] addr_q [NCORES];
    logic [DATA_W-1:0] data_q;

    logic [NCORES-1:0] arb_gnt;
    logic              arb_valid;
    logic [1:0]        arb_idx;
    logic              grant;
    logic              capture;
    logic [ADDR_W-1:0] sel_addr;
    logic              addr_bad;
    logic              setup_last, access_last, hold_last;

    // Cores acked this cycle are masked so a held request is not re-granted at once.
    rr_arbiter4 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (fetch_req),
        .mask      (ack_q),
        .advance   (grant),
        .gnt       (arb_gnt),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    // Address of the core currently winning arbitration, and its range check.
    always_comb begin
        sel_addr    = fetch_addr[32'(arb_idx) * ADDR_W +: ADDR_W];
        addr_bad    = sel_addr >= ADDR_W'(ROM_DEPTH);
        setup_last  = cnt_q == cnt_t'(SETUP_CYC - 1);
        access_last = cnt_q == cnt_t'(ACCESS_CYC - 1);
        hold_last   = cnt_q == cnt_t'(HOLD_CYC - 1);
    end

    // Next-state logic for the access sequencer and registered bus controls.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        core_d  = core_q;
        ack_d   = '0;
        err_d   = '0;
        grant   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    grant  = 1'b1;
                    core_d = arb_idx;
                    if (addr_bad) begin
                        // Rejected without touching the ROM; ack+err next cycle.
                        ack_d = arb_gnt;
                        err_d = arb_gnt;
                    end else begin
                        state_d = StSetup;
                        cnt_d   = '0;
                    end
                end
            end
            StSetup: begin
                if (setup_last) begin
                    state_d = StAccess;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StAccess: begin
                if (access_last) begin
                    capture = 1'b1;
                    state_d = StHold;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StHold: begin
                if (hold_last) begin
                    state_d        = StIdle;
                    cnt_d          = '0;
                    ack_d[core_q]  = 1'b1;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Controls are derived from the next state so the pins come straight from flops.
        ce_n_d = state_d != StAccess;
        oe_n_d = '1;
        if (state_d != StIdle) begin
            oe_n_d[core_d] = 1'b0;
        end
    end

    // Sequencer state and registered ROM/core handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            core_q  <= 2'd0;
            ack_q   <= '0;
            err_q   <= '0;
            oe_n_q  <= '1;
            ce_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            core_q  <= core_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            oe_n_q  <= oe_n_d;
            ce_n_q  <= ce_n_d;
        end
    end

    // Per-core ROM address ports latch only at grant and otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NCORES; k++) begin
                addr_q[k] <= '0;
            end
        end else if (grant) begin
            for (int k = 0; k < NCORES; k++) begin
                if (arb_idx == 2'(k)) begin
                    addr_q[k] <= sel_addr;
                end
            end
        end
    end

    // Only the granted core's lane is refreshed at the end of ACCESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (capture) begin
            for (int k = 0; k < NCORES; k++) begin
                if (core_q == 2'(k)) begin
                    data_q[lane_msb(k) -: LANE_W] <= rom_data[lane_msb(k) -: LANE_W];
                end
            end
        end
    end

    assign fetch_ack  = ack_q;
    assign fetch_err  = err_q;
    assign fetch_data = data_q;
    assign rom_addr1  = addr_q[0];
    assign rom_addr2  = addr_q[1];
    assign rom_addr3  = addr_q[2];
    assign rom_addr4  = addr_q[3];
    assign rom_notOE1 = oe_n_q[0];
    assign rom_notOE2 = oe_n_q[1];
    assign rom_notOE3 = oe_n_q[2];
    assign rom_notOE4 = oe_n_q[3];
    assign rom_notCE  = ce_n_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Bench for rom_fetch_arbiter: a ROM behavioural model drives the bus, and a
// transaction-schedule reference predicts every output cycle by cycle.
module tb_rom_fetch_arbiter;

    localparam int AW    = 54;
    localparam int S     = 3;
    localparam int A     = 3;
    localparam int H     = 3;
    localparam int LAT   = 1 + S + A + H;
    localparam int DEPTH = 4096;
    localparam int MINW  = 3;  // 25 ns at a 10 ns clock, rounded up

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       fetch_req;
    logic [4*AW-1:0]  fetch_addr;
    logic [3:0]       fetch_ack, fetch_err;
    logic [255:0]     fetch_data;
    logic [AW-1:0]    rom_addr1, rom_addr2, rom_addr3, rom_addr4;
    logic             rom_notOE1, rom_notOE2, rom_notOE3, rom_notOE4, rom_notCE;
    logic [255:0]     rom_data;

    rom_fetch_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ack  (fetch_ack),
        .fetch_err  (fetch_err),
        .fetch_data (fetch_data),
        .rom_addr1  (rom_addr1),
        .rom_addr2  (rom_addr2),
        .rom_addr3  (rom_addr3),
        .rom_addr4  (rom_addr4),
        .rom_notOE1 (rom_notOE1),
        .rom_notOE2 (rom_notOE2),
        .rom_notOE3 (rom_notOE3),
        .rom_notOE4 (rom_notOE4),
        .rom_notCE  (rom_notCE),
        .rom_data   (rom_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] row_lane(input logic [AW-1:0] a, input int k);
        if (a == AW'(1)) return 64'(k + 1);
        if (a == AW'(3)) return 64'(k + 5);
        return {a[31:0], 8'(k), 24'hC0FFEE};
    endfunction

    function automatic logic [255:0] rom_row(input logic [AW-1:0] a);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[255-64*k -: 64] = row_lane(a, k);
        return r;
    endfunction

    // The ROM drives the row addressed on whichever port has its output enable low.
    always_comb begin
        rom_data = {4{64'hDEAD_BEEF_0BAD_F00D}};
        if (!rom_notOE1)      rom_data = rom_row(rom_addr1);
        else if (!rom_notOE2) rom_data = rom_row(rom_addr2);
        else if (!rom_notOE3) rom_data = rom_row(rom_addr3);
        else if (!rom_notOE4) rom_data = rom_row(rom_addr4);
    end

    logic [AW-1:0] obs_addr [4];
    logic [3:0]    obs_oe_n;
    assign obs_addr[0] = rom_addr1;
    assign obs_addr[1] = rom_addr2;
    assign obs_addr[2] = rom_addr3;
    assign obs_addr[3] = rom_addr4;
    assign obs_oe_n    = {rom_notOE4, rom_notOE3, rom_notOE2, rom_notOE1};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference model: one access record plus the cycle the controller is next free.
    int            cyc, ptr, acc_core, acc_g, next_free;
    bit            have_acc, acc_err;
    logic [AW-1:0] acc_addr;
    logic [AW-1:0] m_addr [4];
    logic [63:0]   m_lane [4];
    logic [3:0]    m_ack, m_err, m_oe_n, last_ack;
    logic          m_ce_n;
    int            glog [$];
    int            ack_cyc [4];
    int            err_cyc [4];
    int            oe_low_cnt [4];
    int            ce_low_cnt;
    bit            keep [4];

    // Independent ROM timing checker state.
    logic [4*AW+3:0] prev_sig;
    logic            prev_ce;
    int              ce_run, sig_age, rise_age;

    function automatic logic [4*AW+3:0] bus_sig();
        return {obs_oe_n, rom_addr4, rom_addr3, rom_addr2, rom_addr1};
    endfunction

    task automatic model_reset();
        cyc       = 0;
        ptr       = 0;
        have_acc  = 0;
        acc_err   = 0;
        next_free = 0;
        m_ack     = '0;
        last_ack  = '0;
        for (int k = 0; k < 4; k++) begin
            m_addr[k] = '0;
            m_lane[k] = '0;
        end
        prev_sig = {4'hF, {(4*AW){1'b0}}};
        prev_ce  = 1'b1;
        ce_run   = 1000;
        sig_age  = 1000;
        rise_age = 1000;
    endtask

    task automatic mark();
        glog.delete();
        ce_low_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            ack_cyc[k]    = -1;
            err_cyc[k]    = -1;
            oe_low_cnt[k] = 0;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ack"}, 256'(fetch_ack), 256'(0));
        check({pfx, "_err"}, 256'(fetch_err), 256'(0));
        check({pfx, "_data"}, fetch_data, 256'(0));
        check({pfx, "_ce"}, 256'(rom_notCE), 256'(1));
        check({pfx, "_oe"}, 256'(obs_oe_n), 256'(4'hF));
        for (int k = 0; k < 4; k++) check($sformatf("%s_addr%0d", pfx, k), 256'(obs_addr[k]), 256'(0));
    endtask

    // Compare cycle `cyc`, then decide the grant taken at the edge ending it.
    task automatic eval_cycle();
        int              d;
        bit              changed;
        logic [3:0]      elig;
        logic [4*AW+3:0] sig;
        m_ack  = '0;
        m_err  = '0;
        m_oe_n = 4'hF;
        m_ce_n = 1'b1;
        if (have_acc) begin
            d = cyc - acc_g;
            if (acc_err) begin
                if (d == 1) begin
                    m_ack[acc_core] = 1'b1;
                    m_err[acc_core] = 1'b1;
                end
            end else begin
                if (d >= 1 && d <= S + A + H) m_oe_n[acc_core] = 1'b0;
                if (d >= S + 1 && d <= S + A) m_ce_n = 1'b0;
                if (d == S + A + 1) m_lane[acc_core] = row_lane(acc_addr, acc_core);
                if (d == LAT) m_ack[acc_core] = 1'b1;
            end
        end
        check("ack", 256'(fetch_ack), 256'(m_ack));
        check("err", 256'(fetch_err), 256'(m_err));
        check("notCE", 256'(rom_notCE), 256'(m_ce_n));
        check("notOE", 256'(obs_oe_n), 256'(m_oe_n));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("addr%0d", k), 256'(obs_addr[k]), 256'(m_addr[k]));
            check($sformatf("lane%0d", k), 256'(fetch_data[255-64*k -: 64]), 256'(m_lane[k]));
            if (fetch_ack[k]) ack_cyc[k] = cyc;
            if (fetch_err[k]) err_cyc[k] = cyc;
            if (!obs_oe_n[k]) oe_low_cnt[k]++;
        end
        if (!rom_notCE) ce_low_cnt++;

        // ROM timing: widths and address/notOE stability around notCE edges.
        check("oe_one_low", 256'($countones(~obs_oe_n) <= 1), 256'(1));
        check("ce_needs_oe", 256'(rom_notCE || (obs_oe_n != 4'hF)), 256'(1));
        sig     = bus_sig();
        changed = (sig !== prev_sig);
        sig_age = changed ? 1 : sig_age + 1;
        if (rom_notCE !== prev_ce) begin
            if (!rom_notCE) begin
                check("setup_time", 256'(sig_age >= MINW + 1), 256'(1));
                check("ce_high_width", 256'(ce_run >= MINW), 256'(1));
            end else begin
                check("ce_low_width", 256'(ce_run >= MINW), 256'(1));
            end
            ce_run = 1;
        end else begin
            ce_run++;
        end
        rise_age = (rom_notCE && !prev_ce) ? 1 : rise_age + 1;
        if (changed) check("hold_time", 256'(rom_notCE && rise_age >= MINW + 1), 256'(1));
        prev_sig = sig;
        prev_ce  = rom_notCE;

        if (cyc >= next_free) begin
            elig = fetch_req & ~m_ack;
            for (int i = 0; i < 4; i++) begin
                int k;
                k = (ptr + i) % 4;
                if (elig[k]) begin
                    have_acc  = 1;
                    acc_g     = cyc;
                    acc_core  = k;
                    acc_addr  = fetch_addr[k*AW +: AW];
                    acc_err   = acc_addr >= AW'(DEPTH);
                    m_addr[k] = acc_addr;
                    ptr       = (k + 1) % 4;
                    next_free = acc_err ? cyc + 1 : cyc + LAT;
                    glog.push_back(k);
                    break;
                end
            end
        end
        last_ack = m_ack;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [63:0] t;
        int          r;
        r = $urandom_range(0, 9);
        t = {$urandom, $urandom};
        if (r == 0) return t[AW-1:0];
        if (r == 1) return AW'(DEPTH + $urandom_range(0, 3));
        if (r == 2) return AW'(DEPTH - 1);
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    // Core behaviour for the new cycle: drop or renew after ack, random new requests.
    task automatic drive(input bit rnd);
        for (int k = 0; k < 4; k++) begin
            if (!rnd) begin
                if (last_ack[k] && !keep[k]) fetch_req[k] = 1'b0;
            end else if (fetch_req[k]) begin
                if (last_ack[k]) begin
                    if ($urandom_range(0, 1) == 1) fetch_req[k] = 1'b0;
                    else fetch_addr[k*AW +: AW] = rand_addr();
                end else if (have_acc && !acc_err && acc_core == k && cyc > acc_g &&
                             cyc - acc_g < LAT && $urandom_range(0, 7) == 0) begin
                    fetch_req[k] = 1'b0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                fetch_req[k]            = 1'b1;
                fetch_addr[k*AW +: AW] = rand_addr();
            end
        end
    endtask

    task automatic run(input int n, input bit rnd);
        repeat (n) begin
            @(negedge clk);
            eval_cycle();
            @(posedge clk);
            #1;
            cyc++;
            drive(rnd);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        fetch_req = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        mark();
    endtask

    int t0;

    initial begin
        reset      = 1'b1;
        fetch_req  = '0;
        fetch_addr = '0;
        for (int k = 0; k < 4; k++) keep[k] = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        mark();

        // Single fetch of row 1 by core 0.
        t0 = cyc;
        fetch_req[0]          = 1'b1;
        fetch_addr[0*AW +: AW] = AW'(1);
        run(14, 0);
        check("single_ack_lat", 256'(ack_cyc[0] - t0), 256'(10));
        check("single_lane0", 256'(fetch_data[255:192]), 256'(64'd1));
        check("single_other_lanes", 256'(fetch_data[191:0]), 256'(0));
        check("single_ce_low_cycles", 256'(ce_low_cnt), 256'(3));
        check("single_oe1_cycles", 256'(oe_low_cnt[0]), 256'(9));
        check("single_oe_others", 256'(oe_low_cnt[1] + oe_low_cnt[2] + oe_low_cnt[3]), 256'(0));

        // All four cores fetch row 3 together.
        do_reset();
        t0 = cyc;
        for (int k = 0; k < 4; k++) fetch_addr[k*AW +: AW] = AW'(3);
        fetch_req = 4'hF;
        run(45, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("quad_ack_lat%0d", k), 256'(ack_cyc[k] - t0), 256'(10 * (k + 1)));
            check($sformatf("quad_lane%0d", k), 256'(fetch_data[255-64*k -: 64]), 256'(64'(k + 5)));
            check($sformatf("quad_grant%0d", k), 256'(glog.size() > k ? glog[k] : -1), 256'(k));
        end

        // Out-of-range address on core 2.
        mark();
        t0 = cyc;
        fetch_req[2]           = 1'b1;
        fetch_addr[2*AW +: AW] = AW'(DEPTH);
        run(4, 0);
        check("err_ack_lat", 256'(ack_cyc[2] - t0), 256'(1));
        check("err_err_lat", 256'(err_cyc[2] - t0), 256'(1));
        check("err_no_ce", 256'(ce_low_cnt), 256'(0));
        check("err_no_oe", 256'(oe_low_cnt[0] + oe_low_cnt[1] + oe_low_cnt[2] + oe_low_cnt[3]), 256'(0));
        check("err_lane2_kept", 256'(fetch_data[127:64]), 256'(64'd7));

        // Fairness: core 0 holds its request, core 3 asks once.
        do_reset();
        t0 = cyc;
        keep[0]                = 1;
        fetch_req[0]           = 1'b1;
        fetch_addr[0*AW +: AW] = AW'(5);
        run(3, 0);
        fetch_req[3]           = 1'b1;
        fetch_addr[3*AW +: AW] = AW'(6);
        run(22, 0);
        keep[0] = 0;
        run(12, 0);
        check("fair_second_grant", 256'(glog.size() > 1 ? glog[1] : -1), 256'(3));
        check("fair_third_grant", 256'(glog.size() > 2 ? glog[2] : -1), 256'(0));
        check("fair_core3_ack_lat", 256'(ack_cyc[3] - t0), 256'(20));

        // Reset during ACCESS, then a fresh fetch.
        do_reset();
        t0 = cyc;
        fetch_req[1]           = 1'b1;
        fetch_addr[1*AW +: AW] = AW'(9);
        run(5, 0);
        reset     = 1'b1;
        fetch_req = '0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) begin
            @(negedge clk);
            check("midrst_no_ack", 256'(fetch_ack), 256'(0));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        mark();
        t0 = cyc;
        fetch_req[1]           = 1'b1;
        fetch_addr[1*AW +: AW] = AW'(9);
        run(12, 0);
        check("postrst_ack_lat", 256'(ack_cyc[1] - t0), 256'(10));
        check("postrst_lane1", 256'(fetch_data[191:128]), 256'(row_lane(AW'(9), 1)));

        // Randomised traffic against the reference model.
        do_reset();
        run(3000, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
